// File: rtl/led_pwm_ctrl_pkg.sv
// Shared register map, mode encodings and bus payload for the LED PWM controller.
package led_pwm_ctrl_pkg;

    localparam int unsigned LED_ADDR_W = 3;
    localparam int unsigned LED_DATA_W = 32;
    localparam int unsigned LED_STATUS_PHASE_BIT = 16;

    localparam logic [LED_ADDR_W-1:0] LED_PATTERN      = 3'd0;
    localparam logic [LED_ADDR_W-1:0] LED_MODE         = 3'd1;
    localparam logic [LED_ADDR_W-1:0] LED_DUTY         = 3'd2;
    localparam logic [LED_ADDR_W-1:0] LED_BLINK_PERIOD = 3'd3;
    localparam logic [LED_ADDR_W-1:0] LED_STATUS       = 3'd4;
    localparam logic [LED_ADDR_W-1:0] LED_SET          = 3'd5;
    localparam logic [LED_ADDR_W-1:0] LED_CLR          = 3'd6;

    localparam logic [1:0] LED_MODE_STATIC = 2'd0;
    localparam logic [1:0] LED_MODE_BLINK  = 2'd1;
    localparam logic [1:0] LED_MODE_PWM    = 2'd2;
    localparam logic [1:0] LED_MODE_BOTH   = 2'd3;

    typedef struct packed {
        logic                  we;
        logic [LED_ADDR_W-1:0] addr;
        logic [LED_DATA_W-1:0] wdata;
    } led_bus_wr_t;

endpackage

// File: rtl/led_pwm_ctrl_gen.sv
// Free-running PWM counter plus blink half-period counter and phase.
module led_pwm_gen
#(
    parameter int unsigned PWM_BITS = 8,
    parameter int unsigned BLINK_W  = 24
)
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                restart,
    input  logic [BLINK_W-1:0]  period,
    input  logic [PWM_BITS-1:0] duty,
    output logic [PWM_BITS-1:0] pwm_cnt,
    output logic                blink_phase,
    output logic                pwm_on_c
);

    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [BLINK_W-1:0]  blink_cnt_q, blink_cnt_d;
    logic                blink_phase_q, blink_phase_d;

    // A zero period parks the blinker in the lit phase; a period write restarts it.
    always_comb begin
        pwm_cnt_d     = pwm_cnt_q + PWM_BITS'(1);
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (restart || (period == '0)) begin
            blink_cnt_d   = '0;
            blink_phase_d = 1'b1;
        end else if (blink_cnt_q == (period - BLINK_W'(1))) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
        end else begin
            blink_cnt_d   = blink_cnt_q + BLINK_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt_q     <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b1;
        end else begin
            pwm_cnt_q     <= pwm_cnt_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end

    assign pwm_cnt     = pwm_cnt_q;
    assign blink_phase = blink_phase_q;
    assign pwm_on_c    = (pwm_cnt_q < duty);

endmodule

// File: rtl/led_pwm_ctrl.sv
// Memory-mapped LED controller: pattern, blink and PWM gating with registered pins.
module led_pwm_ctrl
    import led_pwm_ctrl_pkg::*;
#(
    parameter int unsigned        N_LED      = 32,
    parameter int unsigned        PWM_BITS   = 8,
    parameter int unsigned        BLINK_W    = 24,
    parameter logic [BLINK_W-1:0] BLINK_RST  = BLINK_W'(5_000_000),
    parameter bit                 ACTIVE_LOW = 1'b1
)
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  We,
    input  logic [LED_ADDR_W-1:0] Addr,
    input  logic [LED_DATA_W-1:0] WD,
    output logic [LED_DATA_W-1:0] RD,
    output logic [N_LED-1:0]      led
);

    led_bus_wr_t         bus_c;
    logic [N_LED-1:0]    pattern_q, pattern_d;
    logic [1:0]          mode_q, mode_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic [BLINK_W-1:0]  period_q, period_d;
    logic [N_LED-1:0]    led_q, led_d;
    logic                restart_c;
    logic                gate_c;
    logic [N_LED-1:0]    lit_c;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                blink_phase;
    logic                pwm_on_c;
    logic [LED_DATA_W-1:0] rd_c;

    assign bus_c     = '{we: We, addr: Addr, wdata: WD};
    assign restart_c = bus_c.we && (bus_c.addr == LED_BLINK_PERIOD);

    led_pwm_gen #(
        .PWM_BITS (PWM_BITS),
        .BLINK_W  (BLINK_W)
    ) u_gen (
        .clk         (clk),
        .rst_n       (reset),
        .restart     (restart_c),
        .period      (period_q),
        .duty        (duty_q),
        .pwm_cnt     (pwm_cnt),
        .blink_phase (blink_phase),
        .pwm_on_c    (pwm_on_c)
    );

    // Register file writes; unused upper write-data bits are dropped.
    always_comb begin
        pattern_d = pattern_q;
        mode_d    = mode_q;
        duty_d    = duty_q;
        period_d  = period_q;
        if (bus_c.we) begin
            case (bus_c.addr)
                LED_PATTERN:      pattern_d = bus_c.wdata[N_LED-1:0];
                LED_MODE:         mode_d    = bus_c.wdata[1:0];
                LED_DUTY:         duty_d    = bus_c.wdata[PWM_BITS-1:0];
                LED_BLINK_PERIOD: period_d  = bus_c.wdata[BLINK_W-1:0];
                LED_SET:          pattern_d = pattern_q | bus_c.wdata[N_LED-1:0];
                LED_CLR:          pattern_d = pattern_q & ~bus_c.wdata[N_LED-1:0];
                default:          ;
            endcase
        end
    end

    // Output gating from the current register and counter state.
    always_comb begin
        gate_c = 1'b1;
        case (mode_q)
            LED_MODE_STATIC: gate_c = 1'b1;
            LED_MODE_BLINK:  gate_c = blink_phase;
            LED_MODE_PWM:    gate_c = pwm_on_c;
            LED_MODE_BOTH:   gate_c = blink_phase & pwm_on_c;
            default:         gate_c = 1'b1;
        endcase
        lit_c = pattern_q & {N_LED{gate_c}};
        led_d = ACTIVE_LOW ? ~lit_c : lit_c;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pattern_q <= '0;
            mode_q    <= LED_MODE_STATIC;
            duty_q    <= '1;
            period_q  <= BLINK_RST;
            led_q     <= {N_LED{ACTIVE_LOW}};
        end else begin
            pattern_q <= pattern_d;
            mode_q    <= mode_d;
            duty_q    <= duty_d;
            period_q  <= period_d;
            led_q     <= led_d;
        end
    end

    // Read mux; write-only and reserved addresses read as zero.
    always_comb begin
        rd_c = '0;
        case (Addr)
            LED_PATTERN:      rd_c[N_LED-1:0]    = pattern_q;
            LED_MODE:         rd_c[1:0]          = mode_q;
            LED_DUTY:         rd_c[PWM_BITS-1:0] = duty_q;
            LED_BLINK_PERIOD: rd_c[BLINK_W-1:0]  = period_q;
            LED_STATUS: begin
                rd_c[LED_STATUS_PHASE_BIT] = blink_phase;
                rd_c[PWM_BITS-1:0]         = pwm_cnt;
            end
            default:          rd_c = '0;
        endcase
    end

    assign RD  = rd_c;
    assign led = led_q;

endmodule

// File: tb/tb_led_pwm_ctrl.sv
// Randomised and directed checks of led_pwm_ctrl against a cycle-count reference model.
module tb_led_pwm_ctrl;

    localparam int unsigned BRST = 5_000_000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        we = 1'b0;
    logic [2:0]  addr = 3'd0;
    logic [31:0] wd = 32'd0;
    logic [31:0] rd;
    logic [31:0] led;
    logic        we2 = 1'b0;
    logic [2:0]  addr2 = 3'd0;
    logic [31:0] wd2 = 32'd0;
    logic [31:0] rd2;
    logic [3:0]  led2;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // reference model: register values, edges since reset, edges since blink restart
    logic [31:0] m_pattern;
    logic [1:0]  m_mode;
    int unsigned m_duty, m_period, m_t, m_bt;
    logic [31:0] exp_led;

    always #5 clk = ~clk;

    led_pwm_ctrl #(.N_LED(32), .PWM_BITS(8), .BLINK_W(24), .BLINK_RST(24'd5_000_000),
                   .ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .reset(reset), .We(we), .Addr(addr), .WD(wd), .RD(rd), .led(led));

    led_pwm_ctrl #(.N_LED(4), .PWM_BITS(4), .BLINK_W(24), .BLINK_RST(24'd5_000_000),
                   .ACTIVE_LOW(1'b0)) dut2 (
        .clk(clk), .reset(reset), .We(we2), .Addr(addr2), .WD(wd2), .RD(rd2), .led(led2));

    function automatic bit phase_at(int unsigned bt, int unsigned p);
        if (p == 0) return 1'b1;
        return ((bt / p) % 2) == 0;
    endfunction

    function automatic logic [31:0] led_model();
        bit g;
        bit ph;
        bit pw;
        ph = phase_at(m_bt, m_period);
        pw = (m_t % 256) < m_duty;
        case (m_mode)
            2'd0:    g = 1'b1;
            2'd1:    g = ph;
            2'd2:    g = pw;
            default: g = ph & pw;
        endcase
        return ~(m_pattern & {32{g}});
    endfunction

    function automatic logic [31:0] rd_model(logic [2:0] a);
        case (a)
            3'd0:    return m_pattern;
            3'd1:    return {30'd0, m_mode};
            3'd2:    return m_duty;
            3'd3:    return m_period;
            3'd4:    return (32'(phase_at(m_bt, m_period)) << 16) | (m_t % 256);
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_pattern = 32'd0;
        m_mode    = 2'd0;
        m_duty    = 255;
        m_period  = BRST;
        m_t       = 0;
        m_bt      = 0;
    endtask

    // One clock edge: expected pins come from pre-edge state, then the write lands.
    task automatic tick();
        @(posedge clk);
        exp_led = led_model();
        m_t++;
        if (we && addr == 3'd3) begin
            m_period = 32'(wd[23:0]);
            m_bt     = 0;
        end else begin
            m_bt++;
        end
        if (we) begin
            case (addr)
                3'd0: m_pattern = wd;
                3'd1: m_mode    = wd[1:0];
                3'd2: m_duty    = 32'(wd[7:0]);
                3'd5: m_pattern = m_pattern | wd;
                3'd6: m_pattern = m_pattern & ~wd;
                default: ;
            endcase
        end
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        we = 1'b1; addr = a; wd = d;
        tick();
        we = 1'b0;
    endtask

    task automatic wr2(input logic [2:0] a, input logic [31:0] d);
        we2 = 1'b1; addr2 = a; wd2 = d;
        tick();
        we2 = 1'b0;
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        #1;
        n_vec++;
        if (led !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL reset_led: got %h want ffffffff", led); end
        n_vec++;
        if (led2 !== 4'h0) begin n_err++; $display("FAIL reset_led2: got %h want 0", led2); end
        @(negedge clk) reset = 1'b1;
        model_reset();
        wr(3'd0, 32'hFFFF_FFFF);
        tick();
        n_vec++;
        if (led !== 32'h0) begin n_err++; $display("FAIL run_all_lit: got %h want 0", led); end
        repeat (7) tick();
        #2 reset = 1'b0;
        #1;
        n_vec++;
        if (led !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL async_reset_led: got %h want ffffffff", led); end
        addr = 3'd0; #1;
        n_vec++;
        if (rd !== 32'h0) begin n_err++; $display("FAIL reset_rd0: got %h want 0", rd); end
        addr = 3'd2; #1;
        n_vec++;
        if (rd !== 32'hFF) begin n_err++; $display("FAIL reset_rd2: got %h want ff", rd); end
        @(negedge clk) reset = 1'b1;
        model_reset();
        addr = 3'd3; #1;
        n_vec++;
        if (rd !== BRST) begin n_err++; $display("FAIL release_rd3: got %h want %h", rd, BRST); end
        addr = 3'd0; #1;
        n_vec++;
        if (rd !== 32'h0) begin n_err++; $display("FAIL release_rd0: got %h want 0", rd); end
    endtask

    task automatic test_static();
        wr(3'd0, 32'h0000_00A5);
        n_vec++;
        if (led !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL static_latency: got %h want ffffffff", led); end
        wr(3'd1, 32'd0);
        n_vec++;
        if (led !== 32'hFFFF_FF5A) begin n_err++; $display("FAIL static_a5: got %h want ffffff5a", led); end
        wr(3'd5, 32'h100);
        wr(3'd6, 32'h1);
        tick();
        addr = 3'd0; #1;
        n_vec++;
        if (rd !== 32'h1A4) begin n_err++; $display("FAIL set_clr_rd: got %h want 1a4", rd); end
        n_vec++;
        if (led !== 32'hFFFF_FE5B) begin n_err++; $display("FAIL set_clr_led: got %h want fffffe5b", led); end
    endtask

    task automatic test_pwm();
        int unsigned lows;
        wr(3'd0, 32'd1);
        wr(3'd2, 32'd64);
        wr(3'd1, 32'd2);
        tick();
        for (int w = 0; w < 4; w++) begin
            lows = 0;
            for (int i = 0; i < 256; i++) begin
                tick();
                n_vec++;
                if (led !== exp_led) begin n_err++; $display("FAIL pwm64_model: got %h want %h", led, exp_led); end
                if (led[0] == 1'b0) lows++;
            end
            n_vec++;
            if (lows != 64) begin n_err++; $display("FAIL pwm64_window: got %0d want 64", lows); end
        end
        wr(3'd2, 32'd0);
        tick();
        for (int i = 0; i < 300; i++) begin
            tick();
            n_vec++;
            if (led[0] !== 1'b1) begin n_err++; $display("FAIL pwm_duty0: got %b want 1", led[0]); end
        end
    endtask

    task automatic test_blink();
        logic want;
        wr(3'd1, 32'd1);
        wr(3'd3, 32'd10);
        for (int i = 1; i <= 25; i++) begin
            tick();
            want = (((i - 1) / 10) % 2) != 0;
            n_vec++;
            if (led[0] !== want) begin n_err++; $display("FAIL blink10 i=%0d: got %b want %b", i, led[0], want); end
        end
        wr(3'd3, 32'd10);
        n_vec++;
        if (led !== exp_led) begin n_err++; $display("FAIL blink_rewrite_edge: got %h want %h", led, exp_led); end
        for (int i = 1; i <= 20; i++) begin
            tick();
            want = (i > 10);
            n_vec++;
            if (led[0] !== want) begin n_err++; $display("FAIL blink_restart i=%0d: got %b want %b", i, led[0], want); end
        end
    endtask

    task automatic test_both();
        int unsigned lows_on, lows_off;
        wr(3'd1, 32'd3);
        wr(3'd2, 32'd128);
        wr(3'd3, 32'd512);
        lows_on = 0; lows_off = 0;
        for (int i = 1; i <= 1024; i++) begin
            tick();
            n_vec++;
            if (led !== exp_led) begin n_err++; $display("FAIL both_model i=%0d: got %h want %h", i, led, exp_led); end
            if (led[0] == 1'b0) begin
                if (i <= 512) lows_on++; else lows_off++;
            end
        end
        n_vec++;
        if (lows_on != 256) begin n_err++; $display("FAIL both_on_phase: got %0d want 256", lows_on); end
        n_vec++;
        if (lows_off != 0) begin n_err++; $display("FAIL both_off_phase: got %0d want 0", lows_off); end
        wr(3'd3, 32'd0);
        tick();
        lows_on = 0;
        for (int i = 0; i < 512; i++) begin
            tick();
            if (led[0] == 1'b0) lows_on++;
        end
        n_vec++;
        if (lows_on != 256) begin n_err++; $display("FAIL period0_pwm: got %0d want 256", lows_on); end
    endtask

    task automatic test_random();
        logic [2:0] ra;
        for (int i = 0; i < 400; i++) begin
            we   = ($urandom_range(0, 1) == 1);
            addr = 3'($urandom_range(0, 7));
            wd   = (addr == 3'd3) ? 32'($urandom_range(0, 30)) : $urandom;
            tick();
            we = 1'b0;
            n_vec++;
            if (led !== exp_led) begin n_err++; $display("FAIL rand_led i=%0d: got %h want %h", i, led, exp_led); end
            ra = 3'($urandom_range(0, 7));
            addr = ra; #1;
            n_vec++;
            if (rd !== rd_model(ra)) begin
                n_err++; $display("FAIL rand_rd a=%0d: got %h want %h", ra, rd, rd_model(ra));
            end
        end
    endtask

    task automatic test_sweep();
        int unsigned ons;
        logic [31:0] want;
        bit wrapped;
        logic [3:0] prev;
        wr2(3'd0, 32'hFF);
        addr2 = 3'd0; #1;
        n_vec++;
        if (rd2 !== 32'hF) begin n_err++; $display("FAIL sweep_rd0: got %h want f", rd2); end
        wr2(3'd1, 32'd0);
        n_vec++;
        if (led2 !== 4'hF) begin n_err++; $display("FAIL sweep_static: got %h want f", led2); end
        wr2(3'd2, 32'd15);
        wr2(3'd1, 32'd2);
        tick();
        addr2 = 3'd4;
        ons = 0; wrapped = 1'b0; prev = 4'd0;
        for (int i = 0; i < 32; i++) begin
            tick();
            if (led2[0] == 1'b1) ons++;
            want = 32'h0001_0000 | (m_t % 16);
            n_vec++;
            if (rd2 !== want) begin n_err++; $display("FAIL sweep_status: got %h want %h", rd2, want); end
            if (i > 0 && prev == 4'd15 && rd2[3:0] == 4'd0) wrapped = 1'b1;
            prev = rd2[3:0];
        end
        n_vec++;
        if (ons != 30) begin n_err++; $display("FAIL sweep_duty15: got %0d want 30", ons); end
        n_vec++;
        if (!wrapped) begin n_err++; $display("FAIL sweep_wrap: got no 15->0 wrap want wrap"); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_static();
        test_pwm();
        test_blink();
        test_both();
        test_random();
        test_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/led_pwm_ctrl.md
Name: led_pwm_ctrl

Overview:
- Memory-mapped LED output controller, successor to the single-register LED port on the CPU bridge.
- Drives N_LED board LEDs with per-bit enable pattern, global blink and global PWM brightness.
- Output polarity is parametrised; default active-low board wiring.
- Sits on the peripheral bus behind the address decoder: word-addressed write/read, one register file.

Parameters:
- N_LED, 32, number of LED outputs (1..32).
- PWM_BITS, 8, PWM counter/duty width (1..16).
- BLINK_W, 24, blink half-period register width (1..32).
- BLINK_RST, 24'd5_000_000, reset value of BLINK_PERIOD.
- ACTIVE_LOW, 1, 1 = led pin driven 0 when lit.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- We  input  1  write strobe, sampled at posedge clk
- Addr  input  3  word address of register
- WD  input  32  write data
- RD  output  32  read data, combinational from Addr
- led  output  N_LED  registered LED pins, polarity per ACTIVE_LOW

Behaviour:
- Register map (Addr): 0 PATTERN rw [N_LED-1:0]; 1 MODE rw [1:0] (0 static, 1 blink, 2 pwm, 3 blink+pwm); 2 DUTY rw [PWM_BITS-1:0]; 3 BLINK_PERIOD rw [BLINK_W-1:0]; 4 STATUS ro {blink_phase at bit 16, pwm_cnt at [PWM_BITS-1:0]}; 5 SET wo (PATTERN |= WD); 6 CLR wo (PATTERN &= ~WD); 7 reserved.
- Unused upper bits: ignored on write, read as 0. Reads of 5,6,7 return 0. Writes to 4,7 ignored.
- Reset (reset==0, async): PATTERN=0, MODE=0, DUTY=all ones, BLINK_PERIOD=BLINK_RST, pwm_cnt=0, blink_cnt=0, blink_phase=1, led = all off (all ones if ACTIVE_LOW, else all zeros). Reset mid-operation aborts everything immediately; release returns to that state.
- pwm_cnt: free-running PWM_BITS counter, +1 every cycle, wraps 2^PWM_BITS-1 -> 0. pwm_on = (pwm_cnt < DUTY). DUTY=0 -> never on; DUTY=max -> on 2^PWM_BITS-1 of every 2^PWM_BITS cycles.
- Blink: blink_cnt counts 0..BLINK_PERIOD-1; on reaching BLINK_PERIOD-1 it returns to 0 and blink_phase toggles (half-period = BLINK_PERIOD cycles). BLINK_PERIOD=0: blink_cnt held 0, blink_phase held 1.
- Write to BLINK_PERIOD: next cycle blink_cnt=0, blink_phase=1 (restart, no stale long interval). Write to MODE or DUTY does not reset counters.
- gate = MODE0: 1; MODE1: blink_phase; MODE2: pwm_on; MODE3: blink_phase & pwm_on.
- lit[i] = PATTERN[i] & gate. led register <= ACTIVE_LOW ? ~lit : lit, every cycle.
- Latency: write at posedge k updates register at k; led reflects new value at posedge k+1.
- RD reflects register contents after last edge (write at edge k visible on RD in cycle after k).
- SET and CLR on same cycle impossible (single Addr). SET/CLR act only on bits [N_LED-1:0].

Decomposition:
- Shared package/header: register address constants (LED_PATTERN..LED_CLR), MODE encodings (LED_MODE_STATIC/BLINK/PWM/BOTH).
- One natural sub-module: led_pwm_gen (pwm_cnt + blink_cnt/phase, outputs pwm_on, blink_phase, counters for STATUS). Register file and output stage stay in top.

Test Plan:
- Reset low mid-run with PATTERN=0xFFFF_FFFF -> led=0xFFFF_FFFF immediately (async), RD@0=0, RD@2=0xFF, RD@3=BLINK_RST after release.
- Write PATTERN=0x0000_00A5, MODE=0 -> led=0xFFFF_FF5A one edge after write; SET 0x100 then CLR 0x1 -> RD@0=0x1A4, led=0xFFFF_FE5B.
- MODE=2, DUTY=64, PATTERN=1 -> led[0] low for exactly 64 of each 256 cycles, over 4 periods; DUTY=0 -> led[0] constantly 1.
- MODE=1, BLINK_PERIOD=10, PATTERN=1 -> led[0] low 10 cycles, high 10 cycles, repeating; rewrite 10 mid-half-period -> low phase restarts for full 10.
- MODE=3, BLINK_PERIOD=512, DUTY=128 -> during on-phase 50% PWM (128/256), during off-phase led[0]=1 throughout; BLINK_PERIOD=0 -> pure PWM.
- Param sweep N_LED=4, PWM_BITS=4, ACTIVE_LOW=0: reset led=0x0; PATTERN=0xFF -> RD@0=0xF; DUTY=15 -> on 15/16 cycles, pwm_cnt in STATUS wraps 15->0.
